// File: rtl/i2c_master_bit_controller_if.sv
// Requester and pad signals of the I2C bit-level master engine.
// Latency: none, wires only.
// Backpressure: cmd_i is held by the requester until cmd_ack_o.
interface i2c_master_bit_controller_if;
  logic        ena_i;
  logic [15:0] clk_cnt_i;
  logic [3:0]  cmd_i;
  logic        cmd_ack_o;
  logic        busy_o;
  logic        al_o;
  logic        dat_i;
  logic        dat_o;
  logic        scl_i;
  logic        sda_i;
  logic        scl_o;
  logic        sda_o;
  logic        scl_dir_o;
  logic        sda_dir_o;

  modport slave (
    input  ena_i, clk_cnt_i, cmd_i, dat_i, scl_i, sda_i,
    output cmd_ack_o, busy_o, al_o, dat_o, scl_o, sda_o, scl_dir_o, sda_dir_o
  );

  modport master (
    output ena_i, clk_cnt_i, cmd_i, dat_i, scl_i, sda_i,
    input  cmd_ack_o, busy_o, al_o, dat_o, scl_o, sda_o, scl_dir_o, sda_dir_o
  );
endinterface

// File: rtl/i2c_master_bit_controller.sv
// I2C bit engine: START/STOP/WRITE/READ primitives on open-drain pads, busy and arbitration detect.
// Latency: 5 (START) or 4 phases of clk_cnt_i+1 cycles each, plus up to one phase to latch the command.
// Backpressure: slave clock stretching or ena_i=0 freezes prescaler and FSM; cmd_i held until cmd_ack_o.
module i2c_master_bit_controller (
  input logic                       clk_i,
  input logic                       rst_n_i,
  i2c_master_bit_controller_if.slave bus
);

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_STA_A, ST_STA_B, ST_STA_C, ST_STA_D, ST_STA_E,
    ST_STO_A, ST_STO_B, ST_STO_C, ST_STO_D,
    ST_WR_A,  ST_WR_B,  ST_WR_C,  ST_WR_D,
    ST_RD_A,  ST_RD_B,  ST_RD_C,  ST_RD_D
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic [2:0]  scl_flt_q, sda_flt_q;
  logic        sscl, ssda, dscl_q, dsda_q;
  logic        sta_cond_q, sto_cond_q, busy_q, dout_q;
  logic [15:0] cnt_q;
  logic        clk_en_q, slave_wait, adv, sda_chk;
  logic        scl_dir_q, scl_dir_d, sda_dir_q, sda_dir_d;
  logic        ack_q, ack_d, al_q, al_d, din_q, din_d;

  assign sscl = (scl_flt_q[0] & scl_flt_q[1]) | (scl_flt_q[0] & scl_flt_q[2]) |
                (scl_flt_q[1] & scl_flt_q[2]);
  assign ssda = (sda_flt_q[0] & sda_flt_q[1]) | (sda_flt_q[0] & sda_flt_q[2]) |
                (sda_flt_q[1] & sda_flt_q[2]);

  // Filters reset to the idle-bus level so no spurious edge follows reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_flt_q  <= 3'b111;
      sda_flt_q  <= 3'b111;
      dscl_q     <= 1'b1;
      dsda_q     <= 1'b1;
      sta_cond_q <= 1'b0;
      sto_cond_q <= 1'b0;
      busy_q     <= 1'b0;
      dout_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[0], bus.sda_i};
      scl_flt_q  <= {scl_flt_q[1:0], scl_sync_q[1]};
      sda_flt_q  <= {sda_flt_q[1:0], sda_sync_q[1]};
      dscl_q     <= sscl;
      dsda_q     <= ssda;
      sta_cond_q <= sscl & dscl_q & dsda_q & ~ssda;
      sto_cond_q <= sscl & dscl_q & ~dsda_q & ssda;
      if (sta_cond_q)
        busy_q <= 1'b1;
      else if (sto_cond_q)
        busy_q <= 1'b0;
      if (sscl && !dscl_q)
        dout_q <= ssda;
    end
  end

  // SCL released by us but still seen low: a slave is stretching the clock.
  assign slave_wait = ~scl_dir_q & ~sscl;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= 16'd0;
      clk_en_q <= 1'b0;
    end else if (!bus.ena_i || slave_wait) begin
      cnt_q    <= bus.clk_cnt_i;
      clk_en_q <= 1'b0;
    end else if (cnt_q == 16'd0) begin
      cnt_q    <= bus.clk_cnt_i;
      clk_en_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_q - 16'd1;
      clk_en_q <= 1'b0;
    end
  end

  assign adv     = clk_en_q & bus.ena_i;
  assign sda_chk = (state_q == ST_WR_B) || (state_q == ST_WR_C) || (state_q == ST_STA_B);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      scl_dir_q <= 1'b0;
      sda_dir_q <= 1'b0;
      ack_q     <= 1'b0;
      al_q      <= 1'b0;
      din_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_dir_q <= scl_dir_d;
      sda_dir_q <= sda_dir_d;
      ack_q     <= ack_d;
      al_q      <= al_d;
      din_q     <= din_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    scl_dir_d = scl_dir_q;
    sda_dir_d = sda_dir_q;
    ack_d     = 1'b0;
    din_d     = din_q;
    // Released SDA read back low while SCL is high means another master won.
    al_d = (sda_chk & ~sda_dir_q & sscl & ~ssda) |
           (sto_cond_q & (state_q != ST_IDLE) & (bus.cmd_i != CMD_STOP));
    if (al_d) begin
      state_d   = ST_IDLE;
      scl_dir_d = 1'b0;
      sda_dir_d = 1'b0;
    end else if (adv) begin
      case (state_q)
        ST_IDLE: begin
          case (bus.cmd_i)
            CMD_START: begin
              state_d   = ST_STA_A;
              sda_dir_d = 1'b0;
            end
            CMD_STOP: begin
              state_d   = ST_STO_A;
              scl_dir_d = 1'b1;
              sda_dir_d = 1'b1;
            end
            CMD_WRITE: begin
              state_d   = ST_WR_A;
              scl_dir_d = 1'b1;
              sda_dir_d = ~bus.dat_i;
              din_d     = bus.dat_i;
            end
            CMD_READ: begin
              state_d   = ST_RD_A;
              scl_dir_d = 1'b1;
              sda_dir_d = 1'b0;
            end
            default: ;
          endcase
        end
        ST_STA_A: begin state_d = ST_STA_B; scl_dir_d = 1'b0; sda_dir_d = 1'b0; end
        ST_STA_B: begin state_d = ST_STA_C; scl_dir_d = 1'b0; sda_dir_d = 1'b1; end
        ST_STA_C: begin state_d = ST_STA_D; scl_dir_d = 1'b0; sda_dir_d = 1'b1; end
        ST_STA_D: begin state_d = ST_STA_E; scl_dir_d = 1'b1; sda_dir_d = 1'b1; end
        ST_STA_E: begin state_d = ST_IDLE;  ack_d = 1'b1; end
        ST_STO_A: begin state_d = ST_STO_B; scl_dir_d = 1'b0; sda_dir_d = 1'b1; end
        ST_STO_B: begin state_d = ST_STO_C; scl_dir_d = 1'b0; sda_dir_d = 1'b1; end
        ST_STO_C: begin state_d = ST_STO_D; scl_dir_d = 1'b0; sda_dir_d = 1'b0; end
        ST_STO_D: begin state_d = ST_IDLE;  ack_d = 1'b1; end
        ST_WR_A:  begin state_d = ST_WR_B;  scl_dir_d = 1'b0; sda_dir_d = ~din_q; end
        ST_WR_B:  begin state_d = ST_WR_C;  scl_dir_d = 1'b0; sda_dir_d = ~din_q; end
        ST_WR_C:  begin state_d = ST_WR_D;  scl_dir_d = 1'b1; sda_dir_d = ~din_q; end
        ST_WR_D:  begin state_d = ST_IDLE;  ack_d = 1'b1; end
        ST_RD_A:  begin state_d = ST_RD_B;  scl_dir_d = 1'b0; sda_dir_d = 1'b0; end
        ST_RD_B:  begin state_d = ST_RD_C;  scl_dir_d = 1'b0; sda_dir_d = 1'b0; end
        ST_RD_C:  begin state_d = ST_RD_D;  scl_dir_d = 1'b1; sda_dir_d = 1'b0; end
        ST_RD_D:  begin state_d = ST_IDLE;  ack_d = 1'b1; end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ack_o = ack_q;
  assign bus.al_o      = al_q;
  assign bus.busy_o    = busy_q;
  assign bus.dat_o     = dout_q;
  assign bus.scl_o     = 1'b0;
  assign bus.sda_o     = 1'b0;
  assign bus.scl_dir_o = scl_dir_q;
  assign bus.sda_dir_o = sda_dir_q;

endmodule

// File: tb/tb_i2c_master_bit_controller.sv
// Bench for the I2C bit engine: open-drain pad model, bus-event scoreboard, stretch/pause/arbitration cases.
// Latency: n/a.
// Backpressure: the bench holds cmd_i until it sees cmd_ack_o.
module tb_i2c_master_bit_controller;

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;
  localparam int EV_BIT0 = 0, EV_BIT1 = 1, EV_START = 2, EV_STOP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slave_scl_low = 1'b0;
  logic slave_sda_low = 1'b0;
  logic scl_line, sda_line;
  int   checks = 0;
  int   errors = 0;
  int   exp_ev[$];

  always #5 clk = ~clk;

  i2c_master_bit_controller_if bus();

  i2c_master_bit_controller dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Wired-AND open-drain bus: low if the DUT or the modelled slave pulls it.
  assign scl_line  = ~bus.scl_dir_o & ~slave_scl_low;
  assign sda_line  = ~bus.sda_dir_o & ~slave_sda_low;
  assign bus.scl_i = scl_line;
  assign bus.sda_i = sda_line;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_event(input int ev);
    if (exp_ev.size() == 0)
      check_val("bus_ev_extra", ev, 99);
    else
      check_val("bus_ev", ev, exp_ev.pop_front());
  endtask

  // Bus observer: START/STOP conditions and completed data bits.
  initial begin
    logic prev_scl, prev_sda, in_bit, bit_val;
    prev_scl = 1'b1; prev_sda = 1'b1; in_bit = 1'b0; bit_val = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_scl && scl_line && prev_sda && !sda_line) begin
          in_bit = 1'b0; bus_event(EV_START);
        end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
          in_bit = 1'b0; bus_event(EV_STOP);
        end else if (!prev_scl && scl_line) begin
          in_bit = 1'b1; bit_val = sda_line;
        end else if (prev_scl && !scl_line && in_bit) begin
          in_bit = 1'b0; bus_event(bit_val ? EV_BIT1 : EV_BIT0);
        end
      end
      prev_scl = scl_line;
      prev_sda = sda_line;
    end
  end

  task automatic do_cmd(input string tag, input logic [3:0] c, input logic d,
                        input int stretch, input int pause, output int cyc);
    bit   got_ack = 0, got_al = 0, stretching = 0, glitch = 0, frozen_bad = 0;
    int   hold = 0;
    logic sda_ref = 1'b0, scl_ref = 1'b0;
    bus.cmd_i = c;
    bus.dat_i = d;
    if (stretch > 0) slave_scl_low = 1'b1;
    cyc = 0;
    while (!got_ack && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.al_o) got_al = 1;
      if (bus.cmd_ack_o) begin
        got_ack   = 1;
        bus.cmd_i = CMD_NOP;
      end
      if (stretch > 0 && slave_scl_low) begin
        if (!stretching && !bus.scl_dir_o) begin
          stretching = 1;
          sda_ref    = bus.sda_dir_o;
        end
        if (stretching) begin
          hold++;
          if (bus.sda_dir_o !== sda_ref) glitch = 1;
          if (hold >= stretch) slave_scl_low = 1'b0;
        end
      end
      if (pause > 0 && cyc == 8 && !got_ack) begin
        scl_ref = bus.scl_dir_o;
        sda_ref = bus.sda_dir_o;
        bus.ena_i = 1'b0;
        repeat (pause) begin
          @(negedge clk);
          cyc++;
          if (bus.cmd_ack_o || bus.scl_dir_o !== scl_ref || bus.sda_dir_o !== sda_ref)
            frozen_bad = 1;
        end
        bus.ena_i = 1'b1;
      end
    end
    slave_scl_low = 1'b0;
    bus.cmd_i     = CMD_NOP;
    check_val({tag, "_ack"}, got_ack, 1);
    check_val({tag, "_al"}, got_al, 0);
    if (got_ack) begin
      @(negedge clk);
      check_val({tag, "_ack_width"}, bus.cmd_ack_o, 0);
    end
    if (stretch > 0) check_val({tag, "_sda_glitch"}, glitch, 0);
    if (pause > 0) check_val({tag, "_frozen"}, frozen_bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int       cyc, al_cnt, ack_cnt;
    bit [7:0] pat;
    logic     b;
    pat = 8'b10100101;
    bus.ena_i     = 1'b1;
    bus.clk_cnt_i = 16'd4;
    bus.cmd_i     = CMD_NOP;
    bus.dat_i     = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_scl_dir", bus.scl_dir_o, 0);
    check_val("rst_sda_dir", bus.sda_dir_o, 0);
    check_val("rst_ack", bus.cmd_ack_o, 0);
    check_val("rst_busy", bus.busy_o, 0);
    check_val("rst_al", bus.al_o, 0);
    check_val("rst_dat_o", bus.dat_o, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    exp_ev.push_back(EV_START);
    do_cmd("start", CMD_START, 1'b0, 0, 0, cyc);
    check_val("start_cycles_in_range", (cyc >= 25 && cyc <= 32), 1);
    check_val("busy_after_start", bus.busy_o, 1);

    for (int i = 0; i < 8; i++) begin
      b = pat[7 - i];
      exp_ev.push_back(b ? EV_BIT1 : EV_BIT0);
      do_cmd("write", CMD_WRITE, b, 0, 0, cyc);
      check_val("write_dat_o", bus.dat_o, b);
    end

    slave_sda_low = 1'b1;
    exp_ev.push_back(EV_BIT0);
    do_cmd("read0", CMD_READ, 1'b0, 0, 0, cyc);
    slave_sda_low = 1'b0;
    check_val("read0_dat_o", bus.dat_o, 0);

    exp_ev.push_back(EV_BIT1);
    do_cmd("wr_stretch", CMD_WRITE, 1'b1, 100, 0, cyc);
    check_val("wr_stretch_delayed", (cyc >= 120), 1);

    exp_ev.push_back(EV_BIT1);
    do_cmd("rd_pause", CMD_READ, 1'b0, 0, 50, cyc);
    check_val("rd_pause_delayed", (cyc >= 70), 1);
    check_val("rd_pause_dat_o", bus.dat_o, 1);

    exp_ev.push_back(EV_STOP);
    do_cmd("stop", CMD_STOP, 1'b0, 0, 0, cyc);
    repeat (10) @(negedge clk);
    check_val("busy_after_stop", bus.busy_o, 0);

    exp_ev.push_back(EV_START);
    do_cmd("start2", CMD_START, 1'b0, 0, 0, cyc);

    // Competing master holds SDA low while we transmit a 1.
    slave_sda_low = 1'b1;
    bus.dat_i     = 1'b1;
    bus.cmd_i     = CMD_WRITE;
    al_cnt = 0;
    ack_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.al_o) begin
        if (al_cnt == 0) begin
          check_val("al_scl_released", bus.scl_dir_o, 0);
          check_val("al_sda_released", bus.sda_dir_o, 0);
          bus.cmd_i = CMD_NOP;
        end
        al_cnt++;
      end
      if (bus.cmd_ack_o) ack_cnt++;
    end
    bus.cmd_i = CMD_NOP;
    check_val("al_pulse_count", al_cnt, 1);
    check_val("al_no_ack", ack_cnt, 0);
    exp_ev.push_back(EV_STOP);
    slave_sda_low = 1'b0;
    repeat (10) @(negedge clk);
    check_val("busy_after_release", bus.busy_o, 0);
    check_val("events_left", exp_ev.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
